// File: rtl/wb_banked_slave_array_if.sv
// Wishbone B4 slave-side bus bundle for the banked RAM array.
// Signal names keep the slave's own _i/_o view of each wire.
interface wb_banked_slave_array_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 2
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic                  cyc_i;
    logic [NUM_SLAVES-1:0] stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [SEL_WIDTH-1:0]  sel_i;
    logic [2:0]            cti_i;
    logic [1:0]            bte_i;
    logic                  ack_o;
    logic                  err_o;
    logic [DATA_WIDTH-1:0] dat_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
        input  ack_o, err_o, dat_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
        output ack_o, err_o, dat_o
    );
endinterface

// File: rtl/wb_banked_slave_array.sv
// NUM_SLAVES byte-enabled RAM banks behind one Wishbone B4 slave port with
// registered-feedback ack, CTI/BTE bursts and error termination.
module wb_banked_slave_array #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    wb_banked_slave_array_if.slave     bus,
    output logic [1:0]                 state_o,
    output logic [CNT_WIDTH-1:0]       xfer_cnt_o
);
    localparam int unsigned BANK_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned MEM_W  = $clog2(NUM_SLAVES * DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StAck  = 2'b01,
        StErr  = 2'b10
    } state_e;

    state_e                 state_q, state_d;
    logic [BANK_W-1:0]      bank_q, bank_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   burst_q, burst_d;
    logic [1:0]             bte_q, bte_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  dat_q, dat_d;

    logic [DATA_WIDTH-1:0]  mem [NUM_SLAVES*DEPTH];

    logic                   req, onehot, adr_ok, beat_done;
    logic [BANK_W-1:0]      req_bank, rd_bank;
    logic [ADDR_WIDTH-1:0]  wrap_mask, addr_inc, rd_addr;
    logic [ADDR_WIDTH:0]    addr_nxt;
    logic [MEM_W-1:0]       rd_idx, wr_idx;

    assign req       = bus.cyc_i & (|bus.stb_i);
    assign onehot    = ((bus.stb_i & (bus.stb_i - NUM_SLAVES'(1))) == '0) && (|bus.stb_i);
    assign adr_ok    = {1'b0, bus.adr_i} < DEPTH_LIM;
    assign beat_done = (state_q == StAck) & bus.cyc_i & bus.stb_i[bank_q];

    always_comb begin
        req_bank = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (bus.stb_i[i]) req_bank = BANK_W'(i);
        end
    end

    // Wrap bursts only advance the low log2(N) address bits.
    always_comb begin
        wrap_mask = '0;
        case (bte_q)
            2'b01:   wrap_mask = ADDR_WIDTH'(3);
            2'b10:   wrap_mask = ADDR_WIDTH'(7);
            2'b11:   wrap_mask = ADDR_WIDTH'(15);
            default: wrap_mask = '0;
        endcase
        addr_inc = addr_q + ADDR_WIDTH'(1);
        if (bte_q == 2'b00) begin
            addr_nxt = {1'b0, addr_q} + (ADDR_WIDTH + 1)'(1);
        end else begin
            addr_nxt = {1'b0, (addr_q & ~wrap_mask) | (addr_inc & wrap_mask)};
        end
    end

    assign rd_bank = (state_q == StIdle) ? req_bank : bank_q;
    assign rd_addr = (state_q == StIdle) ? bus.adr_i : addr_nxt[ADDR_WIDTH-1:0];
    assign rd_idx  = MEM_W'(rd_bank) * MEM_W'(DEPTH) + MEM_W'(rd_addr);
    assign wr_idx  = MEM_W'(bank_q) * MEM_W'(DEPTH) + MEM_W'(addr_q);

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        bte_d   = bte_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (onehot && adr_ok) begin
                        state_d = StAck;
                        bank_d  = req_bank;
                        addr_d  = bus.adr_i;
                        burst_d = (bus.cti_i == 3'b010);
                        bte_d   = bus.bte_i;
                        dat_d   = mem[rd_idx];
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StAck: begin
                if (!bus.cyc_i) begin
                    state_d = StIdle;
                end else if (bus.stb_i[bank_q]) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (burst_q && bus.cti_i == 3'b010) begin
                        if (addr_nxt < DEPTH_LIM) begin
                            addr_d = addr_nxt[ADDR_WIDTH-1:0];
                            dat_d  = mem[rd_idx];
                        end else begin
                            state_d = StErr;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            bank_q  <= '0;
            addr_q  <= '0;
            burst_q <= 1'b0;
            bte_q   <= 2'b00;
            cnt_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            bte_q   <= bte_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
        end
    end

    // RAM is not cleared by reset, but a reset edge must still block the commit.
    always_ff @(posedge clk_i) begin
        if (rst_i && beat_done && bus.we_i) begin
            for (int unsigned b = 0; b < SEL_WIDTH; b++) begin
                if (bus.sel_i[b]) mem[wr_idx][8*b +: 8] <= bus.dat_i[8*b +: 8];
            end
        end
    end

    assign bus.ack_o  = (state_q == StAck);
    assign bus.err_o  = (state_q == StErr);
    assign bus.dat_o  = dat_q;
    assign state_o    = state_q;
    assign xfer_cnt_o = cnt_q;
endmodule

// File: tb/tb_wb_banked_slave_array.sv
// Directed bench for wb_banked_slave_array: classic, burst, error, abort and reset cases.
module tb_wb_banked_slave_array;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  state;
    logic [15:0] cnt;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    wb_banked_slave_array_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_SLAVES(2)) bus ();

    wb_banked_slave_array #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .SEL_WIDTH(4),
        .NUM_SLAVES(2), .DEPTH(8), .CNT_WIDTH(16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .state_o    (state),
        .xfer_cnt_o (cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.cyc_i = 1'b0; bus.stb_i = 2'b00; bus.we_i = 1'b0; bus.adr_i = 4'h0;
        bus.dat_i = 32'h0; bus.sel_i = 4'hF; bus.cti_i = 3'b000; bus.bte_i = 2'b00;
    endtask

    task automatic wr(input logic [1:0] stb, input logic [3:0] adr, input logic [31:0] d,
                      input logic [3:0] sel);
        bus.cyc_i = 1'b1; bus.stb_i = stb; bus.we_i = 1'b1; bus.adr_i = adr;
        bus.dat_i = d; bus.sel_i = sel; bus.cti_i = 3'b000; bus.bte_i = 2'b00;
        step();
        check("wr_ack", bus.ack_o, 1);
        step();
        idle_bus();
        check("wr_ack_drop", bus.ack_o, 0);
    endtask

    task automatic rd(input string tag, input logic [1:0] stb, input logic [3:0] adr,
                      input logic [31:0] exp);
        bus.cyc_i = 1'b1; bus.stb_i = stb; bus.we_i = 1'b0; bus.adr_i = adr;
        bus.cti_i = 3'b000; bus.bte_i = 2'b00;
        step();
        check({tag, "_ack"}, bus.ack_o, 1);
        check(tag, bus.dat_o, exp);
        step();
        idle_bus();
    endtask

    initial begin
        idle_bus();
        step();
        step();
        check("rst_ack", bus.ack_o, 0);
        check("rst_err", bus.err_o, 0);
        check("rst_dat", bus.dat_o, 0);
        check("rst_state", state, 0);
        check("rst_cnt", cnt, 0);
        rst = 1'b1;

        wr(2'b10, 4'd0, 32'h0000_1111, 4'hF);
        rd("t1_rd", 2'b10, 4'd0, 32'h0000_1111);
        check("t1_cnt", cnt, 2);

        wr(2'b01, 4'd0, 32'h1111_0000, 4'hF);
        rd("t2_b1", 2'b10, 4'd0, 32'h0000_1111);
        rd("t2_b0", 2'b01, 4'd0, 32'h1111_0000);

        wr(2'b01, 4'd0, 32'hAAAA_BBBB, 4'b0011);
        rd("t3_sel", 2'b01, 4'd0, 32'h1111_BBBB);
        check("t3_cnt", cnt, 7);

        // Out-of-range address, then a two-hot strobe carrying a write.
        bus.cyc_i = 1'b1; bus.stb_i = 2'b01; bus.adr_i = 4'd9;
        step();
        check("t4a_err", bus.err_o, 1);
        check("t4a_ack", bus.ack_o, 0);
        check("t4a_state", state, 2);
        idle_bus();
        step();
        check("t4a_err_drop", bus.err_o, 0);
        check("t4a_idle", state, 0);
        bus.cyc_i = 1'b1; bus.stb_i = 2'b11; bus.we_i = 1'b1; bus.dat_i = 32'hDEAD_BEEF;
        step();
        check("t4b_err", bus.err_o, 1);
        check("t4b_ack", bus.ack_o, 0);
        idle_bus();
        step();
        check("t4b_err_drop", bus.err_o, 0);
        check("t4_cnt", cnt, 7);
        rd("t4_b0", 2'b01, 4'd0, 32'h1111_BBBB);
        rd("t4_b1", 2'b10, 4'd0, 32'h0000_1111);

        wr(2'b01, 4'd1, 32'h0000_00A1, 4'hF);
        wr(2'b01, 4'd2, 32'h0000_00A2, 4'hF);
        wr(2'b01, 4'd3, 32'h0000_00A3, 4'hF);
        wr(2'b01, 4'd6, 32'h0000_00C6, 4'hF);
        wr(2'b10, 4'd1, 32'h0000_0077, 4'hF);
        check("t5_pre_cnt", cnt, 14);

        // Wrap4 read burst from 2: beats at 2,3,0,1.
        bus.cyc_i = 1'b1; bus.stb_i = 2'b01; bus.we_i = 1'b0; bus.adr_i = 4'd2;
        bus.cti_i = 3'b010; bus.bte_i = 2'b01;
        step();
        check("t5_b2_ack", bus.ack_o, 1);
        check("t5_b2", bus.dat_o, 32'h0000_00A2);
        bus.adr_i = 4'd7;
        step();
        check("t5_b3_ack", bus.ack_o, 1);
        check("t5_b3", bus.dat_o, 32'h0000_00A3);
        step();
        check("t5_b0_ack", bus.ack_o, 1);
        check("t5_b0", bus.dat_o, 32'h1111_BBBB);
        step();
        check("t5_b1_ack", bus.ack_o, 1);
        check("t5_b1", bus.dat_o, 32'h0000_00A1);
        bus.cti_i = 3'b111;
        step();
        idle_bus();
        check("t5_end_ack", bus.ack_o, 0);
        check("t5_end_state", state, 0);
        check("t5_cnt", cnt, 18);

        // Linear burst from 7 overruns DEPTH on the second beat.
        bus.cyc_i = 1'b1; bus.stb_i = 2'b01; bus.adr_i = 4'd7;
        bus.cti_i = 3'b010; bus.bte_i = 2'b00;
        step();
        check("t5l_ack", bus.ack_o, 1);
        step();
        check("t5l_err", bus.err_o, 1);
        check("t5l_ack_drop", bus.ack_o, 0);
        idle_bus();
        step();
        check("t5l_cnt", cnt, 19);

        // Write burst from 4, cyc dropped while the third beat is presented.
        bus.cyc_i = 1'b1; bus.stb_i = 2'b01; bus.we_i = 1'b1; bus.adr_i = 4'd4;
        bus.dat_i = 32'h0000_00B4; bus.cti_i = 3'b010; bus.bte_i = 2'b00;
        step();
        check("t6_ack1", bus.ack_o, 1);
        step();
        bus.dat_i = 32'h0000_00B5;
        check("t6_ack2", bus.ack_o, 1);
        step();
        check("t6_ack3", bus.ack_o, 1);
        bus.cyc_i = 1'b0; bus.dat_i = 32'h0000_00B6;
        step();
        idle_bus();
        check("t6_abort_ack", bus.ack_o, 0);
        check("t6_cnt", cnt, 21);
        rd("t6_a4", 2'b01, 4'd4, 32'h0000_00B4);
        rd("t6_a5", 2'b01, 4'd5, 32'h0000_00B5);
        rd("t6_a6", 2'b01, 4'd6, 32'h0000_00C6);

        // Wait state: strobe low holds ACK without committing.
        bus.cyc_i = 1'b1; bus.stb_i = 2'b01; bus.we_i = 1'b1; bus.adr_i = 4'd6;
        bus.dat_i = 32'h0000_00D6;
        step();
        bus.stb_i = 2'b00;
        step();
        check("ws_ack_hold", bus.ack_o, 1);
        check("ws_state", state, 1);
        check("ws_cnt", cnt, 24);
        bus.stb_i = 2'b01;
        step();
        idle_bus();
        check("ws_ack_drop", bus.ack_o, 0);
        check("ws_cnt2", cnt, 25);
        rd("ws_a6", 2'b01, 4'd6, 32'h0000_00D6);

        // Reset mid-burst: the pending second beat must not commit.
        bus.cyc_i = 1'b1; bus.stb_i = 2'b10; bus.we_i = 1'b1; bus.adr_i = 4'd0;
        bus.dat_i = 32'h0000_5555; bus.cti_i = 3'b010; bus.bte_i = 2'b00;
        step();
        step();
        check("rb_ack", bus.ack_o, 1);
        rst = 1'b0;
        bus.dat_i = 32'h0000_6666;
        step();
        check("rb_ack0", bus.ack_o, 0);
        check("rb_err0", bus.err_o, 0);
        check("rb_dat0", bus.dat_o, 0);
        check("rb_state0", state, 0);
        check("rb_cnt0", cnt, 0);
        rst = 1'b1;
        idle_bus();
        rd("rb_a1", 2'b10, 4'd1, 32'h0000_0077);
        rd("rb_a0", 2'b10, 4'd0, 32'h0000_5555);
        check("rb_cnt", cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
